// File: rtl/cmd_encode.sv
// Command packet transmitter: turns a (type, channel) request into the
// sop / HEAD / TYPE / CHADDR / eop stream consumed by the command decoder.

`ifndef MSG_HEAD
`define MSG_HEAD 16'h434D
`endif
`ifndef MSG_TYPE_HANDSHAKE
`define MSG_TYPE_HANDSHAKE 16'h4853
`endif
`ifndef MSG_TYPE_START
`define MSG_TYPE_START 16'h5354
`endif
`ifndef MSG_TYPE_STOP
`define MSG_TYPE_STOP 16'h5350
`endif

module cmd_encode #(
    parameter int P_DATA_NBIT = 16,
    parameter int P_GAP_NBIT  = 4,
    parameter int P_CNT_NBIT  = 16
) (
    input  logic                   mclk,
    input  logic                   rst_n,
    input  logic                   cmd_req,
    input  logic [1:0]             cmd_type,
    input  logic [7:0]             cmd_chn,
    input  logic [P_GAP_NBIT-1:0]  cmd_gap,
    output logic                   cmd_busy,
    output logic                   cmd_done,
    output logic                   cmd_err,
    output logic                   rx_sop,
    output logic                   rx_vd,
    output logic [P_DATA_NBIT-1:0] rx_data,
    output logic                   rx_eop,
    output logic [P_CNT_NBIT-1:0]  pkt_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SOP    = 3'd1;
    localparam logic [2:0] S_HEAD   = 3'd2;
    localparam logic [2:0] S_TYPE   = 3'd3;
    localparam logic [2:0] S_CHADDR = 3'd4;
    localparam logic [2:0] S_EOP    = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;

    localparam logic [1:0] T_ILLEGAL = 2'd3;

    logic [2:0]            state, nxt_state;
    logic [2:0]            ret_state, nxt_ret;
    logic [P_GAP_NBIT-1:0] gap_cnt, nxt_gap_cnt;
    logic [1:0]            typ_q;
    logic [7:0]            chn_q;
    logic [P_GAP_NBIT-1:0] gap_q;
    logic                  accept;
    logic                  err_nxt;
    logic [15:0]           type_word;
    logic [15:0]           chaddr_word;

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    function automatic logic [2:0] next_beat(input logic [2:0] s);
        case (s)
            S_SOP:    return S_HEAD;
            S_HEAD:   return S_TYPE;
            S_TYPE:   return S_CHADDR;
            S_CHADDR: return S_EOP;
            default:  return S_IDLE;
        endcase
    endfunction

    always_comb begin
        case (typ_q)
            2'd1:    type_word = `MSG_TYPE_START;
            2'd2:    type_word = `MSG_TYPE_STOP;
            default: type_word = `MSG_TYPE_HANDSHAKE;
        endcase
    end

    // Low-nibble digit goes first: the decoder swaps bytes on receipt.
    assign chaddr_word = {hex_ascii(chn_q[3:0]), hex_ascii(chn_q[7:4])};

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        nxt_state   = state;
        nxt_ret     = ret_state;
        nxt_gap_cnt = gap_cnt;
        accept      = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_req) begin
                    if (cmd_type == T_ILLEGAL) begin
                        err_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        nxt_state = S_SOP;
                    end
                end
            end
            S_SOP, S_HEAD, S_TYPE, S_CHADDR: begin
                if (gap_q != '0) begin
                    nxt_state   = S_GAP;
                    nxt_ret     = next_beat(state);
                    nxt_gap_cnt = gap_q;
                end else begin
                    nxt_state = next_beat(state);
                end
            end
            S_GAP: begin
                if (gap_cnt <= P_GAP_NBIT'(1)) begin
                    nxt_state   = ret_state;
                    nxt_gap_cnt = '0;
                end else begin
                    nxt_gap_cnt = gap_cnt - P_GAP_NBIT'(1);
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; outputs are
    // decoded from nxt_state so they are registered alongside the state.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            gap_cnt   <= '0;
            typ_q     <= '0;
            chn_q     <= '0;
            gap_q     <= '0;
            cmd_busy  <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            rx_sop    <= 1'b0;
            rx_vd     <= 1'b0;
            rx_data   <= '0;
            rx_eop    <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            state     <= nxt_state;
            ret_state <= nxt_ret;
            gap_cnt   <= nxt_gap_cnt;
            if (accept) begin
                typ_q <= cmd_type;
                chn_q <= cmd_chn;
                gap_q <= cmd_gap;
            end
            cmd_busy <= (nxt_state != S_IDLE);
            cmd_err  <= err_nxt;
            rx_sop   <= (nxt_state == S_SOP);
            rx_vd    <= (nxt_state == S_HEAD) || (nxt_state == S_TYPE) ||
                        (nxt_state == S_CHADDR);
            rx_eop   <= (nxt_state == S_EOP);
            cmd_done <= (nxt_state == S_EOP);
            case (nxt_state)
                S_HEAD:   rx_data <= `MSG_HEAD;
                S_TYPE:   rx_data <= type_word;
                S_CHADDR: rx_data <= chaddr_word;
                default:  rx_data <= rx_data;
            endcase
            if (nxt_state == S_EOP) begin
                pkt_cnt <= pkt_cnt + P_CNT_NBIT'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmd_encode.sv
// Scoreboard bench for cmd_encode: stimulus pushes time-stamped expected
// beats, a negedge monitor pops and compares whenever the DUT shows activity.

module tb_cmd_encode;

    localparam logic [15:0] W_HEAD = 16'h434D;
    localparam logic [15:0] W_HS   = 16'h4853;
    localparam logic [15:0] W_ST   = 16'h5354;
    localparam logic [15:0] W_SP   = 16'h5350;

    // flag order: {sop, vd, eop, done, err, busy}
    localparam logic [5:0] F_SOP = 6'b100001;
    localparam logic [5:0] F_VD  = 6'b010001;
    localparam logic [5:0] F_EOP = 6'b001101;
    localparam logic [5:0] F_ERR = 6'b000010;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_req = 1'b0;
    logic [1:0]  cmd_type = '0;
    logic [7:0]  cmd_chn = '0;
    logic [3:0]  cmd_gap = '0;
    logic        cmd_busy, cmd_done, cmd_err;
    logic        rx_sop, rx_vd, rx_eop;
    logic [15:0] rx_data;
    logic [15:0] pkt_cnt;

    cmd_encode dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .cmd_req  (cmd_req),
        .cmd_type (cmd_type),
        .cmd_chn  (cmd_chn),
        .cmd_gap  (cmd_gap),
        .cmd_busy (cmd_busy),
        .cmd_done (cmd_done),
        .cmd_err  (cmd_err),
        .rx_sop   (rx_sop),
        .rx_vd    (rx_vd),
        .rx_data  (rx_data),
        .rx_eop   (rx_eop),
        .pkt_cnt  (pkt_cnt)
    );

    always #10 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [5:0]  flags;
        logic [15:0] data;
        bit          chk_data;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input logic [5:0] f, input logic [15:0] d,
                        input bit cd, input logic [15:0] cnt);
        exp_t e;
        e.cyc = c; e.flags = f; e.data = d; e.chk_data = cd; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Push the expected beats of one packet whose SOP shows in cycle s.
    task automatic push_pkt(input int s, input logic [15:0] tw, input logic [15:0] ca,
                            input int g, input int nbeats);
        push(s, F_SOP, '0, 1'b0, exp_cnt);
        if (nbeats > 1) push(s + 1 + g,     F_VD, W_HEAD, 1'b1, exp_cnt);
        if (nbeats > 2) push(s + 2 + 2 * g, F_VD, tw,     1'b1, exp_cnt);
        if (nbeats > 3) push(s + 3 + 3 * g, F_VD, ca,     1'b1, exp_cnt);
        if (nbeats > 4) begin
            exp_cnt = exp_cnt + 16'd1;
            push(s + 4 + 4 * g, F_EOP, '0, 1'b0, exp_cnt);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge mclk);
    endtask

    // One-cycle request; returns the cycle in which SOP is expected.
    task automatic send(input logic [1:0] t, input logic [7:0] c, input logic [3:0] g,
                        input logic [15:0] tw, input logic [15:0] ca, input int nbeats,
                        output int s);
        @(negedge mclk);
        cmd_req = 1'b1; cmd_type = t; cmd_chn = c; cmd_gap = g;
        s = cyc + 1;
        push_pkt(s, tw, ca, int'(g), nbeats);
        @(negedge mclk);
        cmd_req = 1'b0;
    endtask

    always @(negedge mclk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                mon_e = q.pop_front();
                check("missed_beat", 32'(cyc), 32'(mon_e.cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                mon_e = q.pop_front();
                check("flags", {rx_sop, rx_vd, rx_eop, cmd_done, cmd_err, cmd_busy}, mon_e.flags);
                if (mon_e.chk_data) check("rx_data", rx_data, mon_e.data);
                check("pkt_cnt", pkt_cnt, mon_e.cnt);
            end else if (rx_sop || rx_vd || rx_eop || cmd_done || cmd_err) begin
                check("unexpected_strobe", {rx_sop, rx_vd, rx_eop, cmd_done, cmd_err, cmd_busy}, 0);
            end
        end
    end

    initial begin
        int s, s1, s2;

        repeat (3) @(negedge mclk);
        check("reset_strobes", {rx_sop, rx_vd, rx_eop, cmd_done, cmd_err, cmd_busy}, 0);
        check("reset_data", rx_data, 0);
        check("reset_cnt", pkt_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge mclk);

        // Handshake, channel 00, back-to-back beats.
        send(2'd0, 8'h00, 4'd0, W_HS, 16'h3030, 5, s);
        wait_cyc(s + 7);

        // Start, channel 07, two idle cycles after each beat (13-cycle packet).
        send(2'd1, 8'h07, 4'd2, W_ST, 16'h3730, 5, s);
        wait_cyc(s + 15);

        // Illegal type: a lone cmd_err pulse, nothing else.
        @(negedge mclk);
        cmd_req = 1'b1; cmd_type = 2'd3; cmd_chn = 8'h55; cmd_gap = 4'd0;
        s = cyc + 1;
        push(s, F_ERR, '0, 1'b0, exp_cnt);
        @(negedge mclk);
        cmd_req = 1'b0;
        @(negedge mclk);
        check("err_busy_after", cmd_busy, 0);
        check("err_cnt_after", pkt_cnt, 32'(exp_cnt));
        repeat (3) @(negedge mclk);

        // Request held high: two stop packets, channel changed mid-packet.
        @(negedge mclk);
        cmd_req = 1'b1; cmd_type = 2'd2; cmd_chn = 8'hA5; cmd_gap = 4'd0;
        s1 = cyc + 1;
        s2 = s1 + 6;
        push_pkt(s1, W_SP, 16'h3541, 0, 5);
        push_pkt(s2, W_SP, 16'h4333, 0, 5);
        wait_cyc(s1 + 2);
        cmd_chn = 8'h3C;
        wait_cyc(s2);
        cmd_req = 1'b0;
        cmd_chn = 8'h55;
        wait_cyc(s2 + 7);

        // Reset asserted during the TYPE beat.
        send(2'd1, 8'h07, 4'd0, W_ST, 16'h3730, 3, s);
        wait_cyc(s + 2);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_strobes", {rx_sop, rx_vd, rx_eop, cmd_done, cmd_err, cmd_busy}, 0);
        check("async_rst_data", rx_data, 0);
        check("async_rst_cnt", pkt_cnt, 0);
        exp_cnt = '0;
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        repeat (2) @(negedge mclk);

        // Clean packet after reset, hex letters, gap of one.
        send(2'd0, 8'hF9, 4'd1, W_HS, 16'h3946, 5, s);
        wait_cyc(s + 11);

        // Counter wrap from all-ones.
        @(negedge mclk);
        force dut.pkt_cnt = 16'hFFFF;
        #1 release dut.pkt_cnt;
        exp_cnt = 16'hFFFF;
        send(2'd2, 8'h10, 4'd0, W_SP, 16'h3031, 5, s);
        wait_cyc(s + 7);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge mclk);
        check("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_encode.md
Name: cmd_encode

Overview:
- Command packet transmitter producing the RX-side command stream (sop / vd / data / eop) that the FPGA command decoder consumes.
- Turns a compact request (type code, channel number) into the ASCII message {HEAD, TYPE, CHADDR}, with a configurable inter-beat gap.
- Used for on-board loopback self-test of the command path and as a command source for a secondary controller port.
- Sits on mclk and drives the decoder's rx_* inputs through a mux.

Parameters:
- P_DATA_NBIT, 16: word width; equals `USB_DATA_NBIT. Only 16 is supported.
- P_GAP_NBIT, 4: width of the inter-beat gap count.
- P_CNT_NBIT, 16: width of the packet counter.

Ports:
- mclk, input, 1: main clock, 48 MHz.
- rst_n, input, 1: reset.
- cmd_req, input, 1: request. Sampled while idle; level-sensitive.
- cmd_type, input, 2: command type. 0 = HANDSHAKE, 1 = START, 2 = STOP, 3 = illegal.
- cmd_chn, input, 8: channel number, sent as two hex ASCII digits.
- cmd_gap, input, P_GAP_NBIT: number of idle cycles inserted after each beat.
- cmd_busy, output, 1: packet in progress.
- cmd_done, output, 1: one-cycle pulse, coincident with rx_eop.
- cmd_err, output, 1: one-cycle pulse on an illegal request.
- rx_sop, output, 1: start-of-packet strobe.
- rx_vd, output, 1: data valid.
- rx_data, output, P_DATA_NBIT: message word.
- rx_eop, output, 1: end-of-packet strobe.
- pkt_cnt, output, P_CNT_NBIT: count of packets sent.

Behaviour:
- Clock and reset: one clock, mclk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0. State = IDLE, gap counter = 0, pkt_cnt = 0.
- All outputs are registered.
- Reset asserted mid-packet: outputs drop to 0 immediately. No eop is emitted and the partial packet is abandoned.
- States: IDLE, SOP, HEAD, TYPE, CHADDR, EOP, GAP. GAP holds a registered return state.
- IDLE:
  - On a clock edge with cmd_req=1 and cmd_type != 3: latch cmd_type, cmd_chn and cmd_gap, then go to SOP.
  - On a clock edge with cmd_req=1 and cmd_type == 3: pulse cmd_err for one cycle and stay in IDLE. pkt_cnt is unchanged.
- Beat outputs, one cycle each:
  - SOP: rx_sop=1, rx_vd=0.
  - HEAD: rx_vd=1, rx_data=`MSG_HEAD.
  - TYPE: rx_vd=1, rx_data is `MSG_TYPE_HANDSHAKE, `MSG_TYPE_START or `MSG_TYPE_STOP, selected by the latched type.
  - CHADDR: rx_vd=1, rx_data = {ASCII(chn[3:0]), ASCII(chn[7:4])}.
    - The low-nibble digit goes in [15:8]; the high-nibble digit goes in [7:0]. This byte order is required by the decoder's swap.
    - Digits are 0-9 → "0"-"9" and 10-15 → "A"-"F" (uppercase).
    - Example: chn=8'h03 → 16'h3330; chn=8'hA5 → 16'h3541.
    - CHADDR is sent for every type, including HANDSHAKE and STOP.
  - EOP: rx_eop=1, rx_vd=0, cmd_done=1, pkt_cnt+1. pkt_cnt wraps from all-ones to 0.
- Beat sequence is SOP→HEAD→TYPE→CHADDR→EOP→IDLE.
- Gap handling:
  - After each beat except EOP, if the latched gap g > 0, enter GAP for exactly g cycles with all strobes 0, then go to the next beat.
  - rx_data holds its last value during GAP and is don't-care.
  - With g=0 the beats are back-to-back.
- Latency, g=0:
  - Request sampled at edge T.
  - SOP appears in cycle T+1, HEAD in T+2, TYPE in T+3, CHADDR in T+4, EOP in T+5.
  - Packet length is 5 + 4g cycles.
- cmd_busy: 1 in every non-IDLE state and 0 in IDLE.
- Back-to-back requests:
  - A request held high through EOP is accepted on the edge after EOP.
  - The next SOP therefore comes two cycles after the previous EOP, leaving at least one idle cycle between packets.
- Changes to cmd_* while busy are ignored because the values were latched at acceptance.
- cmd_done and cmd_err never assert in the same cycle.

Test Plan:
- Reset, then cmd_req=1 for 1 cycle with type=0, chn=8'h00, gap=0:
  - rx_sop at T+1.
  - vd words {`MSG_HEAD, `MSG_TYPE_HANDSHAKE, 16'h3030} at T+2..T+4.
  - rx_eop=cmd_done at T+5; pkt_cnt=1.
- type=1, chn=8'h07, gap=2:
  - Each beat is separated by exactly 2 zero-strobe cycles.
  - CHADDR=16'h3730; packet length 13 cycles.
  - Feeding the decoder yields ad_acq_en=1 and ad_chn=7.
- type=3: cmd_err pulses 1 cycle; no rx_* activity; pkt_cnt unchanged; cmd_busy stays 0.
- cmd_req held high with type=2, chn=8'hA5:
  - Consecutive packets with SOP two cycles after the previous EOP.
  - CHADDR=16'h3541.
  - Changing cmd_chn mid-packet has no effect on the current packet.
- rst_n low during the TYPE beat: outputs go to 0 asynchronously; no eop. After release, a new request yields a clean full packet.
- Preload pkt_cnt to 16'hFFFF by sending 65535 packets (or by force): the next EOP wraps it to 0.
